// File: rtl/axil_wr_slave.sv
// AXI4-Lite write-only slave over a small register file, with byte-strobe merge and OKAY/SLVERR responses.
// Registers and B update on the edge after the last AW/W handshake. At most one transaction is outstanding; AW/W stall until B is taken.
module axil_wr_slave #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           AWADDR,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [DATA_W-1:0]           WDATA,
    input  logic [DATA_W/8-1:0]         WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_idx
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int NLANE = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-3:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [NLANE-1:0]    strb_q;
    logic                aw_hs;
    logic                w_hs;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                unused_addr_lsb;

    // Array is padded to a power of two; slots at or above NUM_REGS are never written and read as 0.
    logic [DATA_W-1:0]   regs [2**IDX_W];

    assign unused_addr_lsb = ^AWADDR[1:0];
    assign aw_hs    = AWVALID & AWREADY;
    assign w_hs     = WVALID & WREADY;
    assign idx      = addr_q[IDX_W-1:0];
    assign in_range = addr_q < (ADDR_W-2)'(NUM_REGS);
    assign rd_data  = regs[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if ((aw_held | aw_hs) & (w_held | w_hs)) state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    if (BREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is forced low while reset is asserted, not just after the first edge.
    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        if (rst && state == IDLE) begin
            AWREADY = !aw_held;
            WREADY  = !w_held;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            BVALID   <= 1'b0;
            BRESP    <= 2'b00;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (aw_hs) begin
                addr_q  <= AWADDR[ADDR_W-1:2];
                aw_held <= 1'b1;
            end
            if (w_hs) begin
                data_q <= WDATA;
                strb_q <= WSTRB;
                w_held <= 1'b1;
            end
            if (state == WRITE) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BVALID  <= 1'b1;
                if (in_range) begin
                    BRESP    <= 2'b00;
                    wr_pulse <= 1'b1;
                    wr_idx   <= idx;
                end else begin
                    BRESP <= 2'b10;
                end
            end
            if (state == RESP && BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                regs[i] <= '0;
            end
        end else if (state == WRITE && in_range) begin
            for (int b = 0; b < NLANE; b++) begin
                if (strb_q[b]) begin
                    regs[idx][8*b +: 8] <= data_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_axil_wr_slave.sv
// Table-driven and randomized bench for axil_wr_slave against a register-array reference model.
module tb_axil_wr_slave;
    localparam int NREG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [1:0]  rd_idx = '0;
    logic [31:0] rd_data;
    logic        wr_pulse;
    logic [1:0]  wr_idx;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model [NREG];

    axil_wr_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NREG)) dut (
        .clk(clk), .rst(rst),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .rd_idx(rd_idx), .rd_data(rd_data), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        logic        rst_resp;
        logic [1:0]  exp_resp;
        logic        exp_pulse;
        logic [1:0]  exp_idx;
        logic [31:0] exp_reg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Reference outcome of a completed write: response, pulse, and model update.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic pulse, output logic [1:0] idx);
        int word;
        word = int'(addr / 4);
        idx  = 2'(word % NREG);
        if (addr / 4 < NREG) begin
            resp  = 2'b00;
            pulse = 1'b1;
            model[word] = (model[word] & ~lane_mask(strb)) | (data & lane_mask(strb));
        end else begin
            resp  = 2'b10;
            pulse = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bvalid"},   32'(BVALID),   0);
        check({tag, "_bresp"},    32'(BRESP),    0);
        check({tag, "_wr_pulse"}, 32'(wr_pulse), 0);
        check({tag, "_wr_idx"},   32'(wr_idx),   0);
        check({tag, "_awready"},  32'(AWREADY),  0);
        check({tag, "_wready"},   32'(WREADY),   0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            rd_idx = 2'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), rd_data, model[i]);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input logic rst_resp,
                            output logic [1:0] resp, output logic pulse, output logic [1:0] idx);
        logic aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        resp = 2'bxx; pulse = 1'bx; idx = 2'bxx;
        @(posedge clk); #1;
        while (!(aw_done && w_done) && cyc < 50) begin
            AWADDR  = addr; WDATA = data; WSTRB = strb;
            AWVALID = !aw_done && cyc >= aw_dly;
            WVALID  = !w_done && cyc >= w_dly;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            cyc++;
            if (!(aw_done && w_done)) begin
                check("idle_awready", 32'(AWREADY), 32'(!aw_done));
                check("idle_wready",  32'(WREADY),  32'(!w_done));
            end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        if (!(aw_done && w_done)) begin
            check("handshake_timeout", 0, 1);
            return;
        end
        check("write_awready", 32'(AWREADY), 0);
        check("write_wready",  32'(WREADY),  0);
        check("write_bvalid",  32'(BVALID),  0);
        BREADY = (b_dly == 0) && !rst_resp;
        @(posedge clk); #1;
        check("resp_bvalid", 32'(BVALID), 1);
        resp = BRESP; pulse = wr_pulse; idx = wr_idx;
        for (int i = 0; i < b_dly; i++) begin
            AWVALID = 1'b1; WVALID = 1'b1; AWADDR = $urandom;
            @(posedge clk); #1;
            check("stall_bvalid",   32'(BVALID),   1);
            check("stall_bresp",    32'(BRESP),    32'(resp));
            check("stall_wr_pulse", 32'(wr_pulse), 0);
            check("stall_awready",  32'(AWREADY),  0);
            check("stall_wready",   32'(WREADY),   0);
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        if (rst_resp) begin
            #3 rst = 1'b0;
            #1;
            check_reset_outputs("resp_rst");
            for (int i = 0; i < NREG; i++) model[i] = '0;
            #2 rst = 1'b1;
            @(posedge clk); #1;
            check("post_rst_awready", 32'(AWREADY), 1);
            return;
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        check("done_bvalid",   32'(BVALID),   0);
        check("done_wr_pulse", 32'(wr_pulse), 0);
        check("done_awready",  32'(AWREADY),  1);
        check("done_wready",   32'(WREADY),   1);
    endtask

    initial begin
        vec_t vecs [10];
        logic [1:0] r, e_r, i_o, e_i;
        logic p, e_p;
        logic [31:0] a;

        vecs[0] = '{32'h0,         32'hDEADFEED, 4'hF, 0, 0, 0, 1'b0, 2'b00, 1'b1, 2'd0, 32'hDEADFEED};
        vecs[1] = '{32'h8,         32'h12345678, 4'hF, 3, 0, 0, 1'b0, 2'b00, 1'b1, 2'd2, 32'h12345678};
        vecs[2] = '{32'h4,         32'hAAAAAAAA, 4'hF, 0, 2, 1, 1'b0, 2'b00, 1'b1, 2'd1, 32'hAAAAAAAA};
        vecs[3] = '{32'h4,         32'h11223344, 4'h5, 1, 1, 0, 1'b0, 2'b00, 1'b1, 2'd1, 32'hAA22AA44};
        vecs[4] = '{32'h10,        32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0, 2'b10, 1'b0, 2'd0, 32'hDEADFEED};
        vecs[5] = '{32'h1000_0000, 32'hFFFFFFFF, 4'hF, 0, 0, 2, 1'b0, 2'b10, 1'b0, 2'd2, 32'h12345678};
        vecs[6] = '{32'hC,         32'h55667788, 4'h0, 0, 0, 0, 1'b0, 2'b00, 1'b1, 2'd3, 32'h00000000};
        vecs[7] = '{32'hD,         32'h01020304, 4'h3, 2, 0, 0, 1'b0, 2'b00, 1'b1, 2'd3, 32'h00000304};
        vecs[8] = '{32'h0,         32'hCAFEF00D, 4'hF, 0, 0, 5, 1'b1, 2'b00, 1'b1, 2'd0, 32'h00000000};
        vecs[9] = '{32'h8,         32'h0BADBEEF, 4'hC, 0, 1, 0, 1'b0, 2'b00, 1'b1, 2'd2, 32'h0BAD0000};

        for (int i = 0; i < NREG; i++) model[i] = '0;
        #3;
        check_reset_outputs("por");
        check_regs("por");
        #4 rst = 1'b1;
        @(posedge clk); #1;
        check("por_awready", 32'(AWREADY), 1);
        check("por_wready",  32'(WREADY),  1);

        foreach (vecs[k]) begin
            do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].aw_dly, vecs[k].w_dly,
                     vecs[k].b_dly, vecs[k].rst_resp, r, p, i_o);
            check($sformatf("v%0d_bresp", k), 32'(r), 32'(vecs[k].exp_resp));
            check($sformatf("v%0d_pulse", k), 32'(p), 32'(vecs[k].exp_pulse));
            if (vecs[k].exp_pulse)
                check($sformatf("v%0d_wr_idx", k), 32'(i_o), 32'(vecs[k].exp_idx));
            if (!vecs[k].rst_resp)
                model_write(vecs[k].addr, vecs[k].data, vecs[k].strb, e_r, e_p, e_i);
            rd_idx = vecs[k].exp_idx;
            #1;
            check($sformatf("v%0d_reg", k), rd_data, vecs[k].exp_reg);
            check_regs($sformatf("v%0d", k));
        end

        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) a = a | (32'd1 << $urandom_range(4, 31));
            WDATA = $urandom;
            WSTRB = 4'($urandom);
            begin
                logic [31:0] d;
                logic [3:0]  s;
                d = WDATA; s = WSTRB;
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                         1'b0, r, p, i_o);
                model_write(a, d, s, e_r, e_p, e_i);
            end
            check($sformatf("rnd%0d_bresp", t), 32'(r), 32'(e_r));
            check($sformatf("rnd%0d_pulse", t), 32'(p), 32'(e_p));
            if (e_p) check($sformatf("rnd%0d_wr_idx", t), 32'(i_o), 32'(e_i));
            check_regs($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
